tusca: RTL and testbench
========================

TUSCA -- requirements
Module: tusca

Interface
REQ-001 Parameters (name, default, meaning): PERIODO_DELAY, 50_000_000, idle clocks between end of one measurement cycle and next request; CLK_BIT_MEDIDA, 5208, clocks per bit on measurement link (9600 baud at 50 MHz); CLK_BIT_CONFIG, 434, clocks per bit on config link (115200 baud); PERIODO_PWM_VENT, 50_000, fan PWM period in clocks; PERIODO_SERVO, 1_000_000, servo frame in clocks (20 ms); PASSO_SERVO, 25_000_000, clocks per servo step while rotating.
REQ-002 Ports (name direction width meaning), one clock; reset is asynchronous and active-high: clock in 1 system clock 50 MHz; reset in 1 async active-high reset; start in 1 starts measurement loop; definir_config in 1 opens config reception; gira in 1 servo sweep enable; rx_serial_medida in 1 UART from sensor host, idle high; rx_serial_config in 1 UART config, idle high; medir_dht11_out out 1 measurement request pulse; erro_config out 1 config error flag; rele out 1 heater/fan relay; pwm_ventoinha out 1 fan PWM; pwm_servo out 1 servo PWM; db_sel out 1 debug mux select; db_estado out 4 main FSM state; db_estado_interface_dht11 out 4 measurement-interface state; db_estado_config_manager out 4 config FSM state; db_estado_recepcao_config out 4 config UART state; db_estado_recepcao_medida out 4 measurement UART state; db_mux out 16 debug value; db_nivel_temperatura out 3 current level; db_pwm_ventoinha out 1 copy of pwm_ventoinha; db_pwm_servo out 1 copy of pwm_servo; db_rx_serial_config out 1 copy of rx_serial_config; db_rx_serial_medida out 1 copy of rx_serial_medida.

Function
REQ-003 Both UART links: start bit 0, 8 data bits LSB first, odd parity bit (data+parity has odd count of ones), stop bit 1; sample at mid-bit; parity failure flags the byte.
REQ-004 16-bit words arrive low byte first, high byte second.
REQ-005 Main FSM: INICIAL -(start)-> SOLICITA -> AGUARDA -(4 bytes)-> ATUALIZA -> ESPERA -(PERIODO_DELAY clocks)-> SOLICITA; loops until reset.
REQ-006 SOLICITA drives medir_dht11_out high for exactly one clock.
REQ-007 AGUARDA collects temperature word then humidity word; temperature integer = high byte (0x2202 -> 34 C).
REQ-008 Any parity error on measurement bytes discards the cycle (registers unchanged) and goes to ESPERA.
REQ-009 ATUALIZA registers temperature and humidity and recomputes level in one clock.
REQ-010 Config FSM: OCIOSO -(definir_config)-> RECEBE (10 bytes = 5 words) -> VERIFICA -> OCIOSO or ERRO; definir_config also clears erro_config; runs concurrently with main FSM.
REQ-011 Config word k (k=0..4): high byte = threshold k in C, low byte must equal k.
REQ-012 Config valid iff no parity error, every low byte equals index, thresholds strictly increasing; valid -> thresholds committed atomically, erro_config=0; invalid -> thresholds kept, erro_config=1 until next definir_config or reset.
REQ-013 Level (0..5) = number of thresholds <= temperature integer; recomputed when temperature or thresholds change.
REQ-014 rele = 1 iff level > 0.
REQ-015 pwm_ventoinha high for level*PERIODO_PWM_VENT/5 clocks per period (0 %..100 %).
REQ-016 Servo: pulse width 50_000 + pos*12_500 clocks per frame, pos 0..4; gira=1 steps pos every PASSO_SERVO clocks, bouncing 0->4->0; gira=0 holds pos.
REQ-017 db_sel = 1 while config FSM not OCIOSO; db_mux = last config word when db_sel=1, else temperature word.

Reset
REQ-018 Reset: all FSMs in initial states; outputs 0; temperature/humidity 0; thresholds 0xFF (level 0); servo pos 0; erro_config 0; restart needs start.
REQ-019 Reset mid-frame aborts UART reception; partial words discarded.

Structure
REQ-020 Shared package: FSM state encodings, default baud/PWM constants, level width.
REQ-021 One sub-module uart_rx_paridade (parameter clocks per bit; outputs byte, valid pulse, parity error, state), instantiated twice.

Verification
REQ-022 reset, start -> one-clock medir_dht11_out; send 0x2202, 0x1234 on medida -> level 0, rele 0, fan 0 %.
REQ-023 definir_config, then 0x1000,0x2001,0x3002,0x4003,0x5004 on config -> erro_config 0, level 2, rele 1, fan 40 %.
REQ-024 Config sequence with first word 0x2001 -> erro_config 1, thresholds and level unchanged.
REQ-025 Measurement byte with wrong parity -> temperature unchanged, next medir_dht11_out after PERIODO_DELAY.
REQ-026 gira=1 -> servo pulse 50_000, 62_500, ..., 100_000, 87_500 clocks at successive steps; gira=0 holds.

Source files
------------

// File: rtl/tusca_pkg.sv
// rtl/tusca_pkg.sv - shared state encodings, default constants and level helper for tusca
package tusca_pkg;

  localparam int NIVEL_W    = 3;
  localparam int N_LIMIARES = 5;

  localparam int PERIODO_DELAY_DEF     = 50_000_000;
  localparam int CLK_BIT_MEDIDA_DEF    = 5208;
  localparam int CLK_BIT_CONFIG_DEF    = 434;
  localparam int PERIODO_PWM_VENT_DEF  = 50_000;
  localparam int PERIODO_SERVO_DEF     = 1_000_000;
  localparam int PASSO_SERVO_DEF       = 25_000_000;
  localparam int PULSO_SERVO_MIN_DEF   = 50_000;
  localparam int PULSO_SERVO_PASSO_DEF = 12_500;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    SOLICITA = 4'd1,
    AGUARDA  = 4'd2,
    ATUALIZA = 4'd3,
    ESPERA   = 4'd4
  } estado_t;

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    RECEBE   = 4'd1,
    VERIFICA = 4'd2,
    ERRO     = 4'd3
  } estado_cfg_t;

  typedef enum logic [3:0] {
    RX_IDLE     = 4'd0,
    RX_START    = 4'd1,
    RX_DADOS    = 4'd2,
    RX_PARIDADE = 4'd3,
    RX_STOP     = 4'd4
  } estado_rx_t;

  // Level = how many thresholds the integer temperature has reached.
  function automatic logic [NIVEL_W-1:0] calc_nivel(input logic [7:0] temp,
                                                    input logic [N_LIMIARES*8-1:0] limiares);
    logic [NIVEL_W-1:0] n;
    n = '0;
    for (int k = 0; k < N_LIMIARES; k++)
      if (limiares[k*8 +: 8] <= temp) n = n + NIVEL_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/tusca_uart_rx_paridade.sv
// rtl/tusca_uart_rx_paridade.sv - 8O1 UART receiver, mid-bit sampling, flags parity/stop errors
module uart_rx_paridade
  import tusca_pkg::*;
#(
  parameter int CLKS_POR_BIT = CLK_BIT_CONFIG_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_tdata,
  output logic       rx_tvalid,
  output logic       parity_err,
  output logic [3:0] estado
);

  localparam int CW = $clog2(CLKS_POR_BIT) + 1;
  localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_POR_BIT - 1);
  localparam logic [CW-1:0] MEIO_BIT = CW'(CLKS_POR_BIT / 2 - 1);

  estado_rx_t    est, prox;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          rx_s0, rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) est <= RX_IDLE;
    else       est <= prox;
  end

  always_comb begin
    prox = est;
    case (est)
      RX_IDLE:     if (!rx_s) prox = RX_START;
      RX_START:    if (cnt == MEIO_BIT) prox = rx_s ? RX_IDLE : RX_DADOS;
      RX_DADOS:    if (cnt == FIM_BIT && idx == 3'd7) prox = RX_PARIDADE;
      RX_PARIDADE: if (cnt == FIM_BIT) prox = RX_STOP;
      RX_STOP:     if (cnt == FIM_BIT) prox = RX_IDLE;
      default:     prox = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s0      <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_tdata   <= '0;
      rx_tvalid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_s0     <= rx_serial;
      rx_s      <= rx_s0;
      rx_tvalid <= 1'b0;
      if (est == RX_IDLE || est != prox || cnt == FIM_BIT) cnt <= '0;
      else                                                 cnt <= cnt + CW'(1);
      if (est == RX_START) idx <= '0;
      if (est == RX_DADOS && cnt == FIM_BIT) begin
        shreg <= {rx_s, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
      if (est == RX_PARIDADE && cnt == FIM_BIT) par_bit <= rx_s;
      // A missing stop bit is reported through the same error flag as bad parity.
      if (est == RX_STOP && cnt == FIM_BIT) begin
        rx_tvalid  <= 1'b1;
        rx_tdata   <= shreg;
        parity_err <= ~(^{shreg, par_bit}) | ~rx_s;
      end
    end
  end

  assign estado = est;

endmodule

// File: rtl/tusca.sv
// rtl/tusca.sv - temperature loop: measurement request/reception, threshold config, relay, fan PWM, servo sweep
module tusca
  import tusca_pkg::*;
#(
  parameter int PERIODO_DELAY     = PERIODO_DELAY_DEF,
  parameter int CLK_BIT_MEDIDA    = CLK_BIT_MEDIDA_DEF,
  parameter int CLK_BIT_CONFIG    = CLK_BIT_CONFIG_DEF,
  parameter int PERIODO_PWM_VENT  = PERIODO_PWM_VENT_DEF,
  parameter int PERIODO_SERVO     = PERIODO_SERVO_DEF,
  parameter int PASSO_SERVO       = PASSO_SERVO_DEF,
  parameter int PULSO_SERVO_MIN   = PULSO_SERVO_MIN_DEF,
  parameter int PULSO_SERVO_PASSO = PULSO_SERVO_PASSO_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               definir_config,
  input  logic               gira,
  input  logic               rx_serial_medida,
  input  logic               rx_serial_config,
  output logic               medir_dht11_out,
  output logic               erro_config,
  output logic               rele,
  output logic               pwm_ventoinha,
  output logic               pwm_servo,
  output logic               db_sel,
  output logic [3:0]         db_estado,
  output logic [3:0]         db_estado_interface_dht11,
  output logic [3:0]         db_estado_config_manager,
  output logic [3:0]         db_estado_recepcao_config,
  output logic [3:0]         db_estado_recepcao_medida,
  output logic [15:0]        db_mux,
  output logic [NIVEL_W-1:0] db_nivel_temperatura,
  output logic               db_pwm_ventoinha,
  output logic               db_pwm_servo,
  output logic               db_rx_serial_config,
  output logic               db_rx_serial_medida
);

  logic [7:0] med_tdata, cfg_tdata;
  logic       med_tvalid, cfg_tvalid, med_perr, cfg_perr_byte;

  uart_rx_paridade #(.CLKS_POR_BIT(CLK_BIT_MEDIDA)) u_rx_medida (
    .clock(clock), .reset(reset), .rx_serial(rx_serial_medida),
    .rx_tdata(med_tdata), .rx_tvalid(med_tvalid), .parity_err(med_perr),
    .estado(db_estado_recepcao_medida)
  );

  uart_rx_paridade #(.CLKS_POR_BIT(CLK_BIT_CONFIG)) u_rx_config (
    .clock(clock), .reset(reset), .rx_serial(rx_serial_config),
    .rx_tdata(cfg_tdata), .rx_tvalid(cfg_tvalid), .parity_err(cfg_perr_byte),
    .estado(db_estado_recepcao_config)
  );

  // Measurement loop
  estado_t        est, prox;
  logic [31:0]    cnt_espera;
  logic [1:0]     n_bytes;
  logic [3:0][7:0] med_buf;
  logic [15:0]    temperatura, umidade;
  logic           umidade_unused;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) est <= INICIAL;
    else       est <= prox;
  end

  always_comb begin
    prox            = est;
    medir_dht11_out = 1'b0;
    case (est)
      INICIAL:  if (start) prox = SOLICITA;
      SOLICITA: begin
        medir_dht11_out = 1'b1;
        prox            = AGUARDA;
      end
      AGUARDA: begin
        if (med_tvalid) begin
          if (med_perr)            prox = ESPERA;
          else if (n_bytes == 2'd3) prox = ATUALIZA;
        end
      end
      ATUALIZA: prox = ESPERA;
      ESPERA:   if (cnt_espera == 32'(PERIODO_DELAY - 1)) prox = SOLICITA;
      default:  prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_espera  <= '0;
      n_bytes     <= '0;
      med_buf     <= '0;
      temperatura <= '0;
      umidade     <= '0;
    end else begin
      if (est == ESPERA) cnt_espera <= cnt_espera + 32'd1;
      else               cnt_espera <= '0;
      if (est == SOLICITA) n_bytes <= '0;
      if (est == AGUARDA && med_tvalid) begin
        med_buf[n_bytes] <= med_tdata;
        n_bytes          <= n_bytes + 2'd1;
      end
      if (est == ATUALIZA) begin
        temperatura <= {med_buf[1], med_buf[0]};
        umidade     <= {med_buf[3], med_buf[2]};
      end
    end
  end

  assign umidade_unused = ^umidade;

  // Threshold configuration
  estado_cfg_t     est_cfg, prox_cfg;
  logic [3:0]      n_cfg;
  logic [9:0][7:0] cfg_buf;
  logic            cfg_perr;
  logic            cfg_ok;
  logic [N_LIMIARES*8-1:0] limiares;
  logic [15:0]     ultima_palavra;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) est_cfg <= OCIOSO;
    else       est_cfg <= prox_cfg;
  end

  always_comb begin
    cfg_ok = ~cfg_perr;
    for (int k = 0; k < N_LIMIARES; k++)
      if (cfg_buf[2*k] != 8'(k)) cfg_ok = 1'b0;
    for (int k = 0; k < N_LIMIARES - 1; k++)
      if (cfg_buf[2*k+1] >= cfg_buf[2*k+3]) cfg_ok = 1'b0;
  end

  always_comb begin
    prox_cfg = est_cfg;
    if (definir_config) prox_cfg = RECEBE;
    else begin
      case (est_cfg)
        RECEBE:   if (cfg_tvalid && n_cfg == 4'd9) prox_cfg = VERIFICA;
        VERIFICA: prox_cfg = cfg_ok ? OCIOSO : ERRO;
        default:  prox_cfg = est_cfg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_cfg          <= '0;
      cfg_buf        <= '0;
      cfg_perr       <= 1'b0;
      limiares       <= '1;
      ultima_palavra <= '0;
    end else if (definir_config) begin
      n_cfg    <= '0;
      cfg_perr <= 1'b0;
    end else begin
      if (est_cfg == RECEBE && cfg_tvalid) begin
        cfg_buf[n_cfg] <= cfg_tdata;
        n_cfg          <= n_cfg + 4'd1;
        if (cfg_perr_byte) cfg_perr <= 1'b1;
        if (n_cfg[0]) ultima_palavra <= {cfg_tdata, cfg_buf[n_cfg - 4'd1]};
      end
      // All five thresholds move together, only once the whole block checked out.
      if (est_cfg == VERIFICA && cfg_ok)
        limiares <= {cfg_buf[9], cfg_buf[7], cfg_buf[5], cfg_buf[3], cfg_buf[1]};
    end
  end

  logic [NIVEL_W-1:0] nivel;
  assign nivel = calc_nivel(temperatura[15:8], limiares);

  // Fan PWM
  logic [31:0] cnt_pwm, duty;

  always_comb begin
    duty = '0;
    case (nivel)
      3'd1:    duty = 32'(PERIODO_PWM_VENT / 5);
      3'd2:    duty = 32'(PERIODO_PWM_VENT * 2 / 5);
      3'd3:    duty = 32'(PERIODO_PWM_VENT * 3 / 5);
      3'd4:    duty = 32'(PERIODO_PWM_VENT * 4 / 5);
      3'd5:    duty = 32'(PERIODO_PWM_VENT);
      default: duty = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_pwm       <= '0;
      pwm_ventoinha <= 1'b0;
    end else begin
      cnt_pwm       <= (cnt_pwm == 32'(PERIODO_PWM_VENT - 1)) ? '0 : cnt_pwm + 32'd1;
      pwm_ventoinha <= (cnt_pwm < duty);
    end
  end

  // Servo: pulse length is latched at the frame boundary so every frame is clean.
  logic [31:0] cnt_servo, cnt_passo, pulso_len;
  logic [2:0]  pos;
  logic        subindo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_servo <= '0;
      cnt_passo <= '0;
      pulso_len <= 32'(PULSO_SERVO_MIN);
      pos       <= '0;
      subindo   <= 1'b1;
      pwm_servo <= 1'b0;
    end else begin
      pwm_servo <= (cnt_servo < pulso_len);
      if (cnt_servo == 32'(PERIODO_SERVO - 1)) begin
        cnt_servo <= '0;
        pulso_len <= 32'(PULSO_SERVO_MIN) + 32'(pos) * 32'(PULSO_SERVO_PASSO);
      end else begin
        cnt_servo <= cnt_servo + 32'd1;
      end
      if (!gira) begin
        cnt_passo <= '0;
      end else if (cnt_passo == 32'(PASSO_SERVO - 1)) begin
        cnt_passo <= '0;
        if (subindo) begin
          if (pos == 3'd4) begin pos <= 3'd3; subindo <= 1'b0; end
          else             pos <= pos + 3'd1;
        end else begin
          if (pos == 3'd0) begin pos <= 3'd1; subindo <= 1'b1; end
          else             pos <= pos - 3'd1;
        end
      end else begin
        cnt_passo <= cnt_passo + 32'd1;
      end
    end
  end

  assign erro_config               = (est_cfg == ERRO);
  assign rele                      = (nivel != '0);
  assign db_sel                    = (est_cfg != OCIOSO);
  assign db_mux                    = db_sel ? ultima_palavra : temperatura;
  assign db_estado                 = est;
  assign db_estado_interface_dht11 = {2'b00, n_bytes};
  assign db_estado_config_manager  = est_cfg;
  assign db_nivel_temperatura      = nivel;
  assign db_pwm_ventoinha          = pwm_ventoinha;
  assign db_pwm_servo              = pwm_servo;
  assign db_rx_serial_config       = rx_serial_config;
  assign db_rx_serial_medida       = rx_serial_medida;

endmodule

// File: tb/tb_tusca.sv
// tb/tb_tusca.sv - self-checking bench for tusca with scaled timing parameters
module tb_tusca;
  import tusca_pkg::*;

  localparam int DELAY = 200;
  localparam int CPB   = 8;
  localparam int PWM_P = 50;

  logic        clock = 1'b0;
  logic        reset, start, definir_config, gira, rx_serial_medida, rx_serial_config;
  logic        medir_dht11_out, erro_config, rele, pwm_ventoinha, pwm_servo, db_sel;
  logic [3:0]  db_estado, db_estado_interface_dht11, db_estado_config_manager;
  logic [3:0]  db_estado_recepcao_config, db_estado_recepcao_medida;
  logic [15:0] db_mux;
  logic [2:0]  db_nivel_temperatura;
  logic        db_pwm_ventoinha, db_pwm_servo, db_rx_serial_config, db_rx_serial_medida;

  int n_checks = 0;
  int n_fail   = 0;

  tusca #(
    .PERIODO_DELAY(DELAY), .CLK_BIT_MEDIDA(CPB), .CLK_BIT_CONFIG(CPB),
    .PERIODO_PWM_VENT(PWM_P), .PERIODO_SERVO(100), .PASSO_SERVO(300),
    .PULSO_SERVO_MIN(40), .PULSO_SERVO_PASSO(10)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .definir_config(definir_config),
    .gira(gira), .rx_serial_medida(rx_serial_medida), .rx_serial_config(rx_serial_config),
    .medir_dht11_out(medir_dht11_out), .erro_config(erro_config), .rele(rele),
    .pwm_ventoinha(pwm_ventoinha), .pwm_servo(pwm_servo), .db_sel(db_sel),
    .db_estado(db_estado), .db_estado_interface_dht11(db_estado_interface_dht11),
    .db_estado_config_manager(db_estado_config_manager),
    .db_estado_recepcao_config(db_estado_recepcao_config),
    .db_estado_recepcao_medida(db_estado_recepcao_medida), .db_mux(db_mux),
    .db_nivel_temperatura(db_nivel_temperatura), .db_pwm_ventoinha(db_pwm_ventoinha),
    .db_pwm_servo(db_pwm_servo), .db_rx_serial_config(db_rx_serial_config),
    .db_rx_serial_medida(db_rx_serial_medida)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, expected to finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input bit cfg, input logic [7:0] b, input bit bad);
    logic [10:0] quadro;
    logic        par;
    par    = ~(^b) ^ bad;
    quadro = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (cfg) rx_serial_config = quadro[i];
      else     rx_serial_medida = quadro[i];
      tick(CPB);
    end
  endtask

  task automatic send_word(input bit cfg, input logic [15:0] w, input bit bad_lo);
    send_byte(cfg, w[7:0], bad_lo);
    send_byte(cfg, w[15:8], 1'b0);
  endtask

  task automatic pulse_definir();
    definir_config = 1'b1;
    tick(1);
    definir_config = 1'b0;
  endtask

  // w[0] is sent first; bad_idx selects a word whose low byte gets wrong parity.
  task automatic send_cfg(input logic [4:0][15:0] w, input int bad_idx);
    pulse_definir();
    for (int k = 0; k < 5; k++) send_word(1'b1, w[k], k == bad_idx);
    tick(4);
  endtask

  task automatic wait_medir(input int limite, output int ciclos);
    ciclos = -1;
    for (int i = 0; i < limite; i++) begin
      @(negedge clock);
      if (medir_dht11_out) begin
        ciclos = i;
        break;
      end
    end
    if (ciclos < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL medir_timeout: no pulse within %0d clocks, expected one", limite);
    end else begin
      @(negedge clock);
      check("medir_one_clock", medir_dht11_out, 1'b0);
    end
    tick(1);
  endtask

  task automatic measure_fan(output int altos);
    altos = 0;
    repeat (PWM_P) begin
      @(negedge clock);
      if (pwm_ventoinha) altos++;
    end
    tick(1);
  endtask

  task automatic measure_servo(output int largura);
    int guard;
    largura = 0;
    guard   = 0;
    do begin @(negedge clock); guard++; end while (pwm_servo && guard < 300);
    do begin @(negedge clock); guard++; end while (!pwm_servo && guard < 600);
    while (pwm_servo && guard < 900) begin
      largura++;
      guard++;
      @(negedge clock);
    end
    if (guard >= 900) begin
      n_checks++;
      n_fail++;
      $display("FAIL servo_timeout: pulse not framed within 900 clocks, expected a pulse");
    end
  endtask

  typedef struct {
    logic [15:0] temp;
    logic [15:0] umid;
    logic [2:0]  nivel;
    logic        rele;
    int          duty;
  } vet_t;

  vet_t tab[8];

  initial begin
    int c, w, fan;
    int larg[$];
    int esperado_servo[7];

    // thresholds 16,32,48,64,80; fan duty = level*50/5 clocks
    tab[0] = '{16'h0F00, 16'h0101, 3'd0, 1'b0, 0};
    tab[1] = '{16'h1001, 16'h0202, 3'd1, 1'b1, 10};
    tab[2] = '{16'h1F99, 16'h0303, 3'd1, 1'b1, 10};
    tab[3] = '{16'h2202, 16'h1234, 3'd2, 1'b1, 20};
    tab[4] = '{16'h3000, 16'h0404, 3'd3, 1'b1, 30};
    tab[5] = '{16'h4F00, 16'h0505, 3'd4, 1'b1, 40};
    tab[6] = '{16'h5000, 16'h0606, 3'd5, 1'b1, 50};
    tab[7] = '{16'hFF00, 16'h0707, 3'd5, 1'b1, 50};
    esperado_servo = '{40, 50, 60, 70, 80, 70, 60};

    reset = 1'b1; start = 1'b0; definir_config = 1'b0; gira = 1'b0;
    rx_serial_medida = 1'b1; rx_serial_config = 1'b1;
    tick(3);
    check("rst_medir", medir_dht11_out, 1'b0);
    check("rst_erro", erro_config, 1'b0);
    check("rst_rele", rele, 1'b0);
    check("rst_pwm_vent", pwm_ventoinha, 1'b0);
    check("rst_pwm_servo", pwm_servo, 1'b0);
    check("rst_db_sel", db_sel, 1'b0);
    check("rst_estado", db_estado, INICIAL);
    check("rst_estado_cfg", db_estado_config_manager, OCIOSO);
    check("rst_nivel", db_nivel_temperatura, 3'd0);
    check("rst_mux", db_mux, 16'h0000);
    check("rst_rx_copy", db_rx_serial_medida, 1'b1);
    reset = 1'b0;

    tick(20);
    check("no_start_idle", db_estado, INICIAL);
    start = 1'b1; tick(1); start = 1'b0;
    wait_medir(20, c);
    check("after_req_aguarda", db_estado, AGUARDA);

    send_word(1'b0, 16'h2202, 1'b0);
    send_word(1'b0, 16'h1234, 1'b0);
    tick(4);
    check("m0_temp", db_mux, 16'h2202);
    check("m0_nivel", db_nivel_temperatura, 3'd0);
    check("m0_rele", rele, 1'b0);
    measure_fan(fan);
    check("m0_fan", fan, 0);
    check("m0_espera", db_estado, ESPERA);

    pulse_definir();
    tick(2);
    check("cfg_db_sel", db_sel, 1'b1);
    for (int k = 0; k < 5; k++) send_word(1'b1, 16'h1000 + 16'(k) * 16'h1001, 1'b0);
    tick(4);
    check("cfg_ok_erro", erro_config, 1'b0);
    check("cfg_ok_ocioso", db_sel, 1'b0);
    check("cfg_ok_nivel", db_nivel_temperatura, 3'd2);
    check("cfg_ok_rele", rele, 1'b1);
    measure_fan(fan);
    check("cfg_ok_fan", fan, 20);

    send_cfg({16'h5004, 16'h4003, 16'h3002, 16'h2001, 16'h2001}, -1);
    check("cfg_idx_erro", erro_config, 1'b1);
    check("cfg_idx_nivel", db_nivel_temperatura, 3'd2);
    check("cfg_idx_db_sel", db_sel, 1'b1);
    check("cfg_idx_mux", db_mux, 16'h5004);
    pulse_definir();
    tick(1);
    check("definir_clears_erro", erro_config, 1'b0);

    send_cfg({16'h5004, 16'h4003, 16'h3002, 16'h1001, 16'h1000}, -1);
    check("cfg_mono_erro", erro_config, 1'b1);
    check("cfg_mono_nivel", db_nivel_temperatura, 3'd2);

    send_cfg({16'h0504, 16'h0403, 16'h0302, 16'h0201, 16'h0100}, 2);
    check("cfg_par_erro", erro_config, 1'b1);
    check("cfg_par_nivel", db_nivel_temperatura, 3'd2);

    send_cfg({16'h0504, 16'h0403, 16'h0302, 16'h0201, 16'h0100}, -1);
    check("cfg_low_erro", erro_config, 1'b0);
    check("cfg_low_nivel", db_nivel_temperatura, 3'd5);

    send_cfg({16'h5004, 16'h4003, 16'h3002, 16'h2001, 16'h1000}, -1);
    check("cfg_back_nivel", db_nivel_temperatura, 3'd2);
    check("pre_table_aguarda", db_estado, AGUARDA);

    for (int i = 0; i < 8; i++) begin
      send_word(1'b0, tab[i].temp, 1'b0);
      send_word(1'b0, tab[i].umid, 1'b0);
      tick(4);
      check($sformatf("tab%0d_temp", i), db_mux, tab[i].temp);
      check($sformatf("tab%0d_nivel", i), db_nivel_temperatura, tab[i].nivel);
      check($sformatf("tab%0d_rele", i), rele, tab[i].rele);
      measure_fan(fan);
      check($sformatf("tab%0d_fan", i), fan, tab[i].duty);
      wait_medir(400, c);
    end

    send_byte(1'b0, 8'h00, 1'b1);
    tick(2);
    check("par_to_espera", db_estado, ESPERA);
    check("par_temp_kept", db_mux, 16'hFF00);
    wait_medir(400, c);
    check("par_delay_window", (c >= DELAY - 15 && c <= DELAY + 5), 1'b1);
    check("par_temp_still", db_mux, 16'hFF00);

    measure_servo(w);
    check("servo_rest", w, 40);
    gira = 1'b1;
    for (int n = 0; n < 40 && larg.size() < 7; n++) begin
      measure_servo(w);
      if (larg.size() == 0 || larg[larg.size()-1] != w) larg.push_back(w);
    end
    gira = 1'b0;
    check("servo_steps_seen", larg.size(), 7);
    for (int k = 0; k < 7 && k < larg.size(); k++)
      check($sformatf("servo_step%0d", k), larg[k], esperado_servo[k]);
    for (int k = 0; k < 4; k++) begin
      measure_servo(w);
      check($sformatf("servo_hold%0d", k), w, 60);
    end

    tick(1);
    rx_serial_config = 1'b0;
    tick(12);
    check("mid_frame_rx_state", db_estado_recepcao_config, RX_DADOS);
    reset = 1'b1;
    #1;
    check("rst_mid_rx_state", db_estado_recepcao_config, RX_IDLE);
    check("rst_mid_estado", db_estado, INICIAL);
    check("rst_mid_nivel", db_nivel_temperatura, 3'd0);
    check("rst_mid_mux", db_mux, 16'h0000);
    rx_serial_config = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);
    check("rst_mid_rx_idle", db_estado_recepcao_config, RX_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
